// File: rtl/bcd_to_binary_if.sv
// Handshake bundle for bcd_to_binary: packed BCD in with a start pulse,
// binary result out with a data-valid pulse, busy and error flags.
interface bcd_to_binary_if #(
    parameter int DECIMAL_DIGITS = 4,
    parameter int OUTPUT_WIDTH   = 16
);
    logic [DECIMAL_DIGITS*4-1:0] i_BCD;
    logic                        i_Start;
    logic [OUTPUT_WIDTH-1:0]     o_Binary;
    logic                        o_DV;
    logic                        o_Busy;
    logic                        o_Error;

    modport master (
        output i_BCD, i_Start,
        input  o_Binary, o_DV, o_Busy, o_Error
    );

    modport slave (
        input  i_BCD, i_Start,
        output o_Binary, o_DV, o_Busy, o_Error
    );
endinterface

// File: rtl/bcd_to_binary.sv
// Iterative BCD-to-binary converter (reverse double-dabble: shift right, subtract 3).
// Optional invalid-digit checking is enabled by defining BCD_TO_BINARY_CHECK_EN.
module bcd_to_binary #(
    parameter int DECIMAL_DIGITS = 4,
    parameter int OUTPUT_WIDTH   = 16
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    bcd_to_binary_if.slave    bus
);

    localparam int IDX_W = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
    localparam int BCD_W = DECIMAL_DIGITS * 4;

    typedef enum logic [2:0] {
        s_IDLE,
        s_SHIFT,
        s_CHECK_SHIFT_INDEX,
        s_SUB,
        s_CHECK_DIGIT_INDEX,
        s_DONE
    } state_t;

    state_t                  r_State, state_n;
    logic [BCD_W-1:0]        r_BCD, bcd_n;
    logic [OUTPUT_WIDTH-1:0] r_Binary, bin_n;
    logic [7:0]              r_Loop_Count, loop_n;
    logic [IDX_W-1:0]        r_Digit_Index, idx_n;
    logic [OUTPUT_WIDTH-1:0] r_Out, out_n;
    logic                    r_DV, dv_n;

`ifdef BCD_TO_BINARY_CHECK_EN
    logic r_Error, err_n;
    logic r_Invalid, inv_n;
    logic w_Invalid;

    always_comb begin
        w_Invalid = 1'b0;
        for (int unsigned d = 0; d < DECIMAL_DIGITS; d++)
            if (bus.i_BCD[d*4 +: 4] > 4'd9) w_Invalid = 1'b1;
    end

    assign bus.o_Error = r_Error;
`else
    assign bus.o_Error = 1'b0;
`endif

    always_comb begin
        state_n = r_State;
        bcd_n   = r_BCD;
        bin_n   = r_Binary;
        loop_n  = r_Loop_Count;
        idx_n   = r_Digit_Index;
        out_n   = r_Out;
        dv_n    = 1'b0;
`ifdef BCD_TO_BINARY_CHECK_EN
        err_n   = r_Error;
        inv_n   = r_Invalid;
`endif
        case (r_State)
            s_IDLE: begin
                if (bus.i_Start) begin
                    bcd_n   = bus.i_BCD;
                    bin_n   = '0;
                    loop_n  = '0;
                    idx_n   = '0;
                    state_n = s_SHIFT;
`ifdef BCD_TO_BINARY_CHECK_EN
                    inv_n   = w_Invalid;
                    if (w_Invalid) state_n = s_DONE;
`endif
                end
            end
            s_SHIFT: begin
                // BCD and binary registers shift as one concatenated vector
                {bcd_n, bin_n} = {1'b0, r_BCD, r_Binary[OUTPUT_WIDTH-1:1]};
                state_n = s_CHECK_SHIFT_INDEX;
            end
            s_CHECK_SHIFT_INDEX: begin
                if (r_Loop_Count == 8'(OUTPUT_WIDTH - 1)) begin
                    loop_n  = '0;
                    state_n = s_DONE;
                end else begin
                    loop_n  = r_Loop_Count + 8'd1;
                    state_n = s_SUB;
                end
            end
            s_SUB: begin
                for (int unsigned d = 0; d < DECIMAL_DIGITS; d++)
                    if (IDX_W'(d) == r_Digit_Index && r_BCD[d*4 +: 4] >= 4'd8)
                        bcd_n[d*4 +: 4] = r_BCD[d*4 +: 4] - 4'd3;
                state_n = s_CHECK_DIGIT_INDEX;
            end
            s_CHECK_DIGIT_INDEX: begin
                if (r_Digit_Index == IDX_W'(DECIMAL_DIGITS - 1)) begin
                    idx_n   = '0;
                    state_n = s_SHIFT;
                end else begin
                    idx_n   = r_Digit_Index + 1'b1;
                    state_n = s_SUB;
                end
            end
            s_DONE: begin
                dv_n    = 1'b1;
                out_n   = r_Binary;
                state_n = s_IDLE;
`ifdef BCD_TO_BINARY_CHECK_EN
                err_n   = r_Invalid;
                if (r_Invalid) out_n = '0;
`endif
            end
            default: state_n = s_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_State       <= s_IDLE;
            r_BCD         <= '0;
            r_Binary      <= '0;
            r_Loop_Count  <= '0;
            r_Digit_Index <= '0;
            r_Out         <= '0;
            r_DV          <= 1'b0;
`ifdef BCD_TO_BINARY_CHECK_EN
            r_Error       <= 1'b0;
            r_Invalid     <= 1'b0;
`endif
        end else begin
            r_State       <= state_n;
            r_BCD         <= bcd_n;
            r_Binary      <= bin_n;
            r_Loop_Count  <= loop_n;
            r_Digit_Index <= idx_n;
            r_Out         <= out_n;
            r_DV          <= dv_n;
`ifdef BCD_TO_BINARY_CHECK_EN
            r_Error       <= err_n;
            r_Invalid     <= inv_n;
`endif
        end
    end

    assign bus.o_Binary = r_Out;
    assign bus.o_DV     = r_DV;
    assign bus.o_Busy   = (r_State != s_IDLE);

endmodule
